// File: rtl/cnn_out_writeback.sv
// Writes the accelerator's packed output-pixel stream back to SRAM as a contiguous frame,
// buffering through a small FIFO while the SRAM write port is not granted.
module cnn_out_writeback #(
    parameter int unsigned W_DATA       = 32,
    parameter int unsigned W_WORD       = 14,
    parameter int unsigned W_FRAME_SIZE = 25,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    i_start,
    input  logic [W_WORD-1:0]       i_base_addr,
    input  logic [W_FRAME_SIZE-1:0] i_frame_size,
    input  logic [W_DATA-1:0]       i_pixel,
    input  logic                    i_valid,
    input  logic                    i_gnt,
    output logic                    o_sram_en,
    output logic                    o_sram_we,
    output logic [W_WORD-1:0]       o_sram_addr,
    output logic [W_DATA-1:0]       o_sram_wdata,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_overflow
);

    localparam int unsigned W_PTR = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned W_IDX = W_PTR - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Each entry carries its own address so dropped beats leave a hole, not a shift.
    typedef struct packed {
        logic [W_WORD-1:0] addr;
        logic [W_DATA-1:0] data;
    } wb_entry_t;

    state_t                  state_q,    state_d;
    logic [W_WORD-1:0]       base_q,     base_d;
    logic [W_FRAME_SIZE-1:0] size_q,     size_d;
    logic [W_FRAME_SIZE-1:0] acc_q,      acc_d;
    logic [W_PTR-1:0]        wr_ptr_q,   wr_ptr_d;
    logic [W_PTR-1:0]        rd_ptr_q,   rd_ptr_d;
    logic                    overflow_q, overflow_d;
    logic                    busy_q,     busy_d;
    logic                    done_q,     done_d;
    logic                    sram_en_q,  sram_en_d;
    logic [W_WORD-1:0]       sram_addr_q,  sram_addr_d;
    logic [W_DATA-1:0]       sram_wdata_q, sram_wdata_d;

    wb_entry_t fifo_mem_q [FIFO_DEPTH];

    logic      empty_c;
    logic      full_c;
    logic      pop_c;
    logic      beat_c;
    logic      push_c;
    logic      drop_c;
    logic      start_ok_c;
    wb_entry_t head_c;
    wb_entry_t push_entry_c;

    // Next-state, FIFO control and output register inputs
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        size_d       = size_q;
        acc_d        = acc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        overflow_d   = overflow_q;
        sram_en_d    = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;

        empty_c = (wr_ptr_q == rd_ptr_q);
        full_c  = (wr_ptr_q[W_PTR-1] != rd_ptr_q[W_PTR-1]) &&
                  (wr_ptr_q[W_IDX-1:0] == rd_ptr_q[W_IDX-1:0]);
        head_c  = fifo_mem_q[rd_ptr_q[W_IDX-1:0]];
        pop_c   = !empty_c && i_gnt;
        beat_c  = (state_q == RUN) && i_valid && (acc_q < size_q);
        push_c  = beat_c && (!full_c || pop_c);
        drop_c  = beat_c && full_c && !pop_c;
        start_ok_c = i_start && ((state_q == IDLE) || (state_q == DONE));

        push_entry_c.addr = base_q + W_WORD'(acc_q);
        push_entry_c.data = i_pixel;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + W_PTR'(1);
        end
        if (pop_c) begin
            rd_ptr_d     = rd_ptr_q + W_PTR'(1);
            sram_en_d    = 1'b1;
            sram_addr_d  = head_c.addr;
            sram_wdata_d = head_c.data;
        end
        if (drop_c) begin
            overflow_d = 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start_ok_c) begin
                    base_d     = i_base_addr;
                    size_d     = i_frame_size;
                    acc_d      = '0;
                    overflow_d = 1'b0;
                    state_d    = (i_frame_size == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (beat_c) begin
                    acc_d = acc_q + W_FRAME_SIZE'(1);
                    if (acc_d == size_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (empty_c) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q      <= IDLE;
            base_q       <= '0;
            size_q       <= '0;
            acc_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sram_en_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            size_q       <= size_d;
            acc_q        <= acc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sram_en_q    <= sram_en_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge HCLK) begin
        if (push_c) begin
            fifo_mem_q[wr_ptr_q[W_IDX-1:0]] <= push_entry_c;
        end
    end

    assign o_sram_en    = sram_en_q;
    assign o_sram_we    = sram_en_q;
    assign o_sram_addr  = sram_addr_q;
    assign o_sram_wdata = sram_wdata_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_overflow   = overflow_q;

endmodule
